// File: rtl/cache_req_driver_pkg.sv
// rtl/cache_req_driver_pkg.sv - shared types and defaults for the cache request driver
package cache_req_driver_pkg;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT    = 64;
    localparam int DEF_CNT_W      = 16;
    localparam int REQ_W          = 65;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_LOCAL
    } state_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

endpackage

// File: rtl/cache_req_driver_req_fifo.sv
// rtl/cache_req_driver_req_fifo.sv - in-order request queue feeding the issue FSM
module req_fifo
    import cache_req_driver_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  req_t                    wdata,
    output req_t                    rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    req_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    // A pop in the same cycle frees the slot, so a full queue can still take a push.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/cache_req_driver.sv
// rtl/cache_req_driver.sv - queues processor requests and drives the change-detected cache inputs
module cache_req_driver
    import cache_req_driver_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_miss,
    output logic              rsp_timeout,
    output logic [31:0]       cache_data,
    output logic [31:0]       cache_addr,
    output logic              cache_wr,
    input  logic              cache_response,
    input  logic              cache_is_missrate,
    input  logic [31:0]       cache_out,
    output logic              busy,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int WCW = $clog2(TIMEOUT) + 1;

    state_t                   state_q, state_d;
    req_t                     head, wr_entry;
    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic [31:0]              cache_data_q, cache_data_d;
    logic [31:0]              cache_addr_q, cache_addr_d;
    logic                     cache_wr_q, cache_wr_d;
    logic [WCW-1:0]           wait_cnt_q, wait_cnt_d;

    logic                     rsp_valid_q, rsp_valid_d;
    logic [31:0]              rsp_data_q, rsp_data_d;
    logic                     rsp_miss_q, rsp_miss_d;
    logic                     rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]         hit_cnt_q, hit_cnt_d, hit_cnt_inc;
    logic [CNT_W-1:0]         miss_cnt_q, miss_cnt_d, miss_cnt_inc;

    assign wr_entry  = '{wr: req_wr, addr: req_addr, data: req_data};
    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;

    req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign hit_cnt_inc  = (&hit_cnt_q)  ? hit_cnt_q  : hit_cnt_q  + CNT_W'(1);
    assign miss_cnt_inc = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        fifo_pop      = 1'b0;
        cache_data_d  = cache_data_q;
        cache_addr_d  = cache_addr_q;
        cache_wr_d    = cache_wr_q;
        wait_cnt_d    = wait_cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = '0;
        rsp_miss_d    = 1'b0;
        rsp_timeout_d = 1'b0;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head.wr && cache_wr_q && (head.addr == cache_addr_q) &&
                        (head.data == cache_data_q)) begin
                        state_d = ST_LOCAL;
                    end else if (!head.wr && !cache_wr_q && (head.addr == cache_addr_q)) begin
                        // Data is ignored by the cache on reads, so flipping it forces a visible change.
                        cache_data_d = ~cache_data_q;
                        state_d      = ST_ISSUE;
                    end else begin
                        cache_wr_d   = head.wr;
                        cache_addr_d = head.addr;
                        cache_data_d = head.wr ? head.data : 32'h0;
                        state_d      = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if ((wait_cnt_q == '0) && !cache_wr_q && !cache_is_missrate) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cache_out;
                    hit_cnt_d   = hit_cnt_inc;
                    state_d     = ST_IDLE;
                end else if (cache_response) begin
                    rsp_valid_d = 1'b1;
                    if (!cache_wr_q) begin
                        rsp_data_d = cache_out;
                        rsp_miss_d = cache_is_missrate;
                        if (cache_is_missrate) begin
                            miss_cnt_d = miss_cnt_inc;
                        end else begin
                            hit_cnt_d = hit_cnt_inc;
                        end
                    end
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ST_LOCAL: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cache_data_q  <= '0;
            cache_addr_q  <= '0;
            cache_wr_q    <= 1'b0;
            wait_cnt_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_miss_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cache_data_q  <= cache_data_d;
            cache_addr_q  <= cache_addr_d;
            cache_wr_q    <= cache_wr_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_miss_q    <= rsp_miss_d;
            rsp_timeout_q <= rsp_timeout_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign cache_data  = cache_data_q;
    assign cache_addr  = cache_addr_q;
    assign cache_wr    = cache_wr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_miss    = rsp_miss_q;
    assign rsp_timeout = rsp_timeout_q;
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;
    assign busy        = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule
